// File: rtl/gcd_operand_feeder.sv
// Operand feeder for the GCD unit: pairs serial A/B beats into {A,B} words
// and queues them in a small FIFO with a valid/ready output handshake.
module gcd_operand_feeder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       io_op_valid,
    input  logic [WIDTH-1:0]           io_op_data,
    output logic                       io_op_ready,
    output logic                       io_out_valid,
    output logic [2*WIDTH-1:0]         io_out_data,
    input  logic                       io_out_ready,
    output logic [$clog2(DEPTH+1)-1:0] io_count,
    output logic                       io_phase_b
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] mem_q [DEPTH];

    logic full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && io_out_ready;

    // The A beat never touches the FIFO, so PH_A is always ready; only the
    // B beat depends on a free entry, and it never looks at io_out_ready.
    always_comb begin
        phase_d     = phase_q;
        a_d         = a_q;
        io_op_ready = 1'b1;
        push        = 1'b0;
        unique case (phase_q)
            PH_A: begin
                io_op_ready = 1'b1;
                if (io_op_valid) begin
                    a_d     = io_op_data;
                    phase_d = PH_B;
                end
            end
            PH_B: begin
                io_op_ready = !full;
                if (io_op_valid && !full) begin
                    push    = 1'b1;
                    phase_d = PH_A;
                end
            end
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q  <= PH_A;
            a_q      <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            a_q      <= a_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {a_q, io_op_data};
        end
    end

    assign io_out_valid = !empty;
    assign io_out_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign io_count     = count_q;
    assign io_phase_b   = (phase_q == PH_B);

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Randomized bench for gcd_operand_feeder: a queue-based model of the pairing
// and FIFO behaviour is compared against the DUT on every falling edge.
module tb_gcd_operand_feeder;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_op_valid;
    logic [15:0] io_op_data;
    logic        io_op_ready;
    logic        io_out_valid;
    logic [31:0] io_out_data;
    logic        io_out_ready;
    logic [2:0]  io_count;
    logic        io_phase_b;

    logic rnd_mode, rnd_rdy, man_rdy;
    assign io_out_ready = rnd_mode ? rnd_rdy : man_rdy;

    gcd_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .io_op_valid (io_op_valid),
        .io_op_data  (io_op_data),
        .io_op_ready (io_op_ready),
        .io_out_valid(io_out_valid),
        .io_out_data (io_out_data),
        .io_out_ready(io_out_ready),
        .io_count    (io_count),
        .io_phase_b  (io_phase_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a queue of packed words, a phase bit and the held A.
    logic [31:0] m_q[$];
    bit          m_ph;
    logic [15:0] m_a;
    bit          m_acc;
    logic [31:0] cap[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_loop();
        bit rdy, pop;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_q.delete();
                m_ph  = 1'b0;
                m_a   = '0;
                m_acc = 1'b0;
            end else begin
                rdy   = !m_ph || (m_q.size() < DEPTH);
                m_acc = io_op_valid && rdy;
                pop   = io_out_ready && (m_q.size() != 0);
                if (pop) void'(m_q.pop_front());
                if (m_acc) begin
                    if (m_ph) m_q.push_back({m_a, io_op_data});
                    else      m_a = io_op_data;
                    m_ph = !m_ph;
                end
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("out_valid", 32'(io_out_valid), 32'(m_q.size() != 0));
            chk("out_data",  io_out_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
            chk("count",     32'(io_count), 32'(m_q.size()));
            chk("phase_b",   32'(io_phase_b), 32'(m_ph));
            chk("op_ready",  32'(io_op_ready), 32'(!m_ph || m_q.size() < DEPTH));
            if (reset && io_out_valid && io_out_ready) cap.push_back(io_out_data);
        end
    endtask

    task automatic rnd_loop();
        forever begin
            @(posedge clk);
            #1;
            rnd_rdy = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d);
        bit done = 1'b0;
        io_op_valid = 1'b1;
        io_op_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            cyc();
            done = m_acc;
        end
        if (!done) chk("beat_timeout", 32'd0, 32'd1);
        io_op_valid = 1'b0;
    endtask

    task automatic beat_stall(input logic [15:0] d);
        repeat ($urandom_range(0, 2)) cyc();
        beat(d);
    endtask

    task automatic drain();
        rnd_mode = 1'b0;
        man_rdy  = 1'b1;
        for (int i = 0; i < 300 && m_q.size() != 0; i++) cyc();
        man_rdy = 1'b0;
        cyc();
        chk("drain_count", 32'(io_count), 32'd0);
    endtask

    function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    initial begin
        logic [31:0] exp_w;
        int unsigned exp_g[3];
        reset       = 1'b0;
        io_op_valid = 1'b0;
        io_op_data  = '0;
        man_rdy     = 1'b0;
        rnd_mode    = 1'b0;
        rnd_rdy     = 1'b0;
        fork
            model_loop();
            compare_loop();
            rnd_loop();
        join_none

        #2;
        chk("rst_valid", 32'(io_out_valid), 32'd0);
        chk("rst_data",  io_out_data, 32'd0);
        chk("rst_ready", 32'(io_op_ready), 32'd1);
        chk("rst_count", 32'(io_count), 32'd0);
        chk("rst_phase", 32'(io_phase_b), 32'd0);
        repeat (3) cyc();
        reset = 1'b1;
        cyc();

        // Single pair, held under back-pressure.
        beat(16'h0030);
        chk("single_phase_a", 32'(io_phase_b), 32'd1);
        beat(16'h0012);
        chk("single_valid", 32'(io_out_valid), 32'd1);
        chk("single_data",  io_out_data, 32'h0030_0012);
        chk("single_count", 32'(io_count), 32'd1);
        chk("single_phase", 32'(io_phase_b), 32'd0);
        repeat (5) begin
            cyc();
            chk("single_hold", io_out_data, 32'h0030_0012);
        end
        drain();

        // Fill to full, stall B, release with one pop, then drain in order.
        cap.delete();
        for (int k = 0; k < 4; k++) begin
            beat(16'h1000 + 16'(k));
            beat(16'h2000 + 16'(k));
        end
        chk("full_count", 32'(io_count), 32'd4);
        beat(16'h1004);
        chk("full_a_held", 32'(io_phase_b), 32'd1);
        io_op_valid = 1'b1;
        io_op_data  = 16'h2004;
        repeat (3) cyc();
        chk("full_b_stall", 32'(io_op_ready), 32'd0);
        chk("full_b_count", 32'(io_count), 32'd4);
        man_rdy = 1'b1;
        cyc();
        man_rdy = 1'b0;
        chk("full_after_pop_ready", 32'(io_op_ready), 32'd1);
        beat(16'h2004);
        chk("full_refill_count", 32'(io_count), 32'd4);
        drain();
        chk("full_cap_size", 32'(cap.size()), 32'd5);
        for (int k = 0; k < 5 && k < cap.size(); k++) begin
            exp_w = {16'h1000 + 16'(k), 16'h2000 + 16'(k)};
            chk("full_order", cap[k], exp_w);
        end

        // Wrap-around with random back-pressure and source stalls.
        cap.delete();
        rnd_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            beat_stall(16'(i));
            beat_stall(16'(i + 100));
        end
        drain();
        chk("wrap_cap_size", 32'(cap.size()), 32'd10);
        for (int i = 0; i < 10 && i < cap.size(); i++) begin
            exp_w = {16'(i), 16'(i + 100)};
            chk("wrap_order", cap[i], exp_w);
        end

        // Push and pop on the same edge with one entry buffered.
        beat(16'h0AAA);
        beat(16'h0BBB);
        beat(16'h0CCC);
        man_rdy = 1'b1;
        beat(16'h0DDD);
        man_rdy = 1'b0;
        chk("pp_count", 32'(io_count), 32'd1);
        chk("pp_data",  io_out_data, 32'h0CCC_0DDD);
        drain();

        // Random traffic.
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            beat_stall(16'($urandom));
            beat_stall(($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom));
        end
        drain();

        // Reset in the middle: two entries buffered and an A held.
        beat(16'h1111);
        beat(16'h2222);
        beat(16'h3333);
        beat(16'h4444);
        beat(16'h5555);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(io_out_valid), 32'd0);
        chk("mid_rst_count", 32'(io_count), 32'd0);
        chk("mid_rst_phase", 32'(io_phase_b), 32'd0);
        chk("mid_rst_data",  io_out_data, 32'd0);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        beat(16'h0005);
        chk("post_rst_is_a", 32'(io_phase_b), 32'd1);
        beat(16'h0007);
        chk("post_rst_data", io_out_data, 32'h0005_0007);
        drain();

        // GCD-style consumer: ready only while idle, a few busy cycles per job.
        cap.delete();
        beat(16'd48); beat(16'd18);
        beat(16'd7);  beat(16'd0);
        beat(16'd0);  beat(16'd5);
        for (int k = 0; k < 3; k++) begin
            man_rdy = 1'b1;
            cyc();
            man_rdy = 1'b0;
            repeat (4) cyc();
        end
        chk("gcd_count", 32'(io_count), 32'd0);
        chk("gcd_jobs", 32'(cap.size()), 32'd3);
        exp_g[0] = 6;
        exp_g[1] = 7;
        exp_g[2] = 5;
        for (int k = 0; k < 3 && k < cap.size(); k++)
            chk("gcd_result", gcd(32'(cap[k][31:16]), 32'(cap[k][15:0])), exp_g[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcd_operand_feeder.md
Name: gcd_operand_feeder

Overview:
- Upstream stage of the GCD unit. Accepts a serial stream of 16-bit operands, two beats per request: first beat A, second beat B.
- Packs each pair into the 32-bit request word the GCD consumes, with A in [31:16] and B in [15:0].
- Buffers packed requests in a DEPTH-entry FIFO.
- Presents requests to the GCD input port with a valid/ready handshake, so the operand source can run ahead while the GCD iterates.

Parameters:
- WIDTH, 16, operand width; output word is 2*WIDTH.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- io_op_valid  input  1  operand beat valid.
- io_op_data  input  WIDTH  operand beat value.
- io_op_ready  output  1  feeder accepts operand beat this cycle.
- io_out_valid  output  1  packed request available (drives GCD io_in_valid).
- io_out_data  output  2*WIDTH  packed request {A,B} (drives GCD io_in_data).
- io_out_ready  input  1  consumer accepts request (from GCD io_in_ready).
- io_count  output  $clog2(DEPTH+1)  number of FIFO entries occupied.
- io_phase_b  output  1  1 = holding A, waiting for the B beat.

Behaviour:
- Reset (reset==0, asynchronous):
  - phase=PH_A, A holding reg=0, rd_ptr=wr_ptr=0, count=0.
  - Outputs: io_out_valid=0, io_out_data=0, io_op_ready=1, io_count=0, io_phase_b=0.
  - A partially assembled pair is discarded. Buffered requests are discarded.
- Beat accept: io_op_valid & io_op_ready at posedge.
- FSM PH_A:
  - io_op_ready=1 unconditionally (A goes to the holding reg, not the FIFO).
  - On accept: a_reg<=io_op_data, phase<=PH_B.
- FSM PH_B:
  - io_op_ready = (count != DEPTH). Purely state-based; no combinational path from io_out_ready.
  - On accept: push {a_reg, io_op_data} into the FIFO, phase<=PH_A.
- Source stall: io_op_valid low in either phase leaves state unchanged; the A value is held indefinitely.
- Output side:
  - io_out_valid = (count != 0).
  - io_out_data = mem[rd_ptr]; equals 0 when empty. Stable while valid & !ready.
  - Pop on io_out_valid & io_out_ready: rd_ptr+1.
- Latency: B accepted at edge N makes the request visible with io_out_valid=1 in cycle N+1 when the FIFO was empty. No same-cycle bypass.
- Simultaneous push and pop: both occur; count unchanged; pointers each advance.
  - Cannot occur when full (io_op_ready=0 in PH_B).
  - When count==1, the popped entry is the old head; the new head is the pushed entry.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH naturally. Count is a separate register, so full and empty are unambiguous.
- Full: A may still be accepted and held. B stalls until a pop frees an entry.
- Empty: io_out_valid=0; io_out_ready is ignored.
- No arithmetic on operand values. Zero operands pass through unmodified; zero handling belongs to the GCD.
- Downstream GCD asserts io_in_ready only when idle, so at most one pop occurs per GCD computation. The feeder imposes no rate limit itself.

Test Plan:
- Single pair: reset, beats 0x0030 then 0x0012, io_out_ready=0 -> cycle after B: io_out_valid=1, io_out_data=0x00300012, io_count=1, io_phase_b=0. Data holds for 5 stalled cycles.
- Fill to full: DEPTH=4, push 4 pairs with io_out_ready=0 -> io_count=4.
  - Fifth A beat is accepted (io_phase_b=1); its B beat sees io_op_ready=0.
  - Raise io_out_ready for 1 cycle -> pop, io_op_ready=1, B accepted, io_count=4.
  - Pops then drain in push order.
- Wrap-around: push/pop 10 pairs (A=i, B=i+100) with interleaved stalls -> output order and values exact, pointers wrap twice, io_count returns to 0.
- Simultaneous push/pop at count==1: B accept and pop on the same edge -> io_count stays 1; io_out_data becomes the new pair next cycle.
- Reset mid-operation: assert reset after an A beat with 2 entries buffered -> immediately io_out_valid=0, io_count=0, io_phase_b=0. After release, the next beat is treated as A.
- GCD integration: feeder drives the GCD; pairs (48,18), (7,0), (0,5) -> feeder pops each only when the GCD io_in_ready=1; GCD results match the reference model in order.
